// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm bank: FSM mode encoding and channel-select width.
package alarm_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StEdit   = 3'd1,
    StRing   = 3'd2,
    StSnooze = 3'd3
  } alarm_mode_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/edge_det.sv
// Registers a button level and emits a one-cycle pulse on its rising edge.
module edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic pulse_o
);

  logic level_q;
  logic prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      level_q <= level_i;
      prev_q  <= level_q;
    end
  end

  assign pulse_o = level_q & ~prev_q;

endmodule

// File: rtl/alarm_bank.sv
// Multi-channel alarm clock: per-channel hour/minute/armed storage, edit flow,
// ring with snooze, all driven from a 1 Hz tick and three buttons.
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_ALARMS  = 4,
  parameter int unsigned TIME_W      = 11,
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned SNOOZE_MAX  = 3,
  localparam int unsigned CH_W       = ch_width(NUM_ALARMS)
) (
  input  logic                  newclk,
  input  logic                  rst,
  input  logic                  tick_1hz,
  input  logic [TIME_W-1:0]     hour,
  input  logic [TIME_W-1:0]     minute,
  input  logic [TIME_W-1:0]     second,
  input  logic                  middle,
  input  logic                  dismiss,
  input  logic                  arm_toggle,
  input  logic [CH_W-1:0]       sel,
  output logic [2:0]            alarm_mode,
  output logic                  do_ring,     // ring drive ('do' is a reserved word)
  output logic [CH_W-1:0]       ring_ch,
  output logic [NUM_ALARMS-1:0] armed
);

  localparam int unsigned MaxSecs = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int unsigned CntW    = $clog2(MaxSecs + 1);
  localparam int unsigned SnzW    = (SNOOZE_MAX > 0) ? $clog2(SNOOZE_MAX + 1) : 1;

  logic mid_ev, dis_ev, arm_ev;

  edge_det u_mid_det (.clk_i(newclk), .rst_i(rst), .level_i(middle),     .pulse_o(mid_ev));
  edge_det u_dis_det (.clk_i(newclk), .rst_i(rst), .level_i(dismiss),    .pulse_o(dis_ev));
  edge_det u_arm_det (.clk_i(newclk), .rst_i(rst), .level_i(arm_toggle), .pulse_o(arm_ev));

  alarm_mode_e           state_q;
  logic                  do_q;
  logic [CH_W-1:0]       ring_ch_q;
  logic [CH_W-1:0]       edit_ch_q;
  logic [NUM_ALARMS-1:0] armed_q;
  logic [CntW-1:0]       cnt_q;
  logic [SnzW-1:0]       snz_q;
  logic [TIME_W-1:0]     shadow_hour_q;
  logic [TIME_W-1:0]     shadow_min_q;
  logic [TIME_W-1:0]     alm_hour_q [NUM_ALARMS];
  logic [TIME_W-1:0]     alm_min_q  [NUM_ALARMS];

  logic            hit;
  logic [CH_W-1:0] hit_ch;
  logic            sel_ok;
  logic            edit_ok;

  // Scan downwards so the lowest matching channel is the one left standing.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
      if (armed_q[i] && alm_hour_q[i] == hour && alm_min_q[i] == minute) begin
        hit    = 1'b1;
        hit_ch = CH_W'(i);
      end
    end
  end

  assign sel_ok  = 32'(sel) < NUM_ALARMS;
  assign edit_ok = 32'(edit_ch_q) < NUM_ALARMS;

  always_ff @(posedge newclk) begin
    if (rst) begin
      state_q       <= StIdle;
      do_q          <= 1'b0;
      ring_ch_q     <= '0;
      edit_ch_q     <= '0;
      armed_q       <= '0;
      cnt_q         <= '0;
      snz_q         <= '0;
      shadow_hour_q <= '0;
      shadow_min_q  <= '0;
      for (int i = 0; i < int'(NUM_ALARMS); i++) begin
        alm_hour_q[i] <= '0;
        alm_min_q[i]  <= '0;
      end
    end else begin
      if (state_q == StEdit) begin
        shadow_hour_q <= hour;
        shadow_min_q  <= minute;
      end
      unique case (state_q)
        StIdle: begin
          if (mid_ev) begin
            state_q   <= StEdit;
            edit_ch_q <= sel;
          end else if (tick_1hz && second == '0 && hit) begin
            state_q   <= StRing;
            do_q      <= 1'b1;
            ring_ch_q <= hit_ch;
            cnt_q     <= '0;
            snz_q     <= '0;
          end
          if (arm_ev && sel_ok) armed_q[sel] <= ~armed_q[sel];
        end
        StEdit: begin
          if (dis_ev) begin
            state_q <= StIdle;
          end else if (mid_ev) begin
            state_q <= StIdle;
            if (edit_ok) begin
              alm_hour_q[edit_ch_q] <= shadow_hour_q;
              alm_min_q[edit_ch_q]  <= shadow_min_q;
              armed_q[edit_ch_q]    <= 1'b1;
            end
          end
        end
        StRing: begin
          if (dis_ev) begin
            state_q <= StIdle;
            do_q    <= 1'b0;
          end else if (mid_ev) begin
            do_q  <= 1'b0;
            cnt_q <= '0;
            if (32'(snz_q) < SNOOZE_MAX) begin
              state_q <= StSnooze;
              snz_q   <= snz_q + SnzW'(1);
            end else begin
              state_q <= StIdle;
            end
          end else if (tick_1hz) begin
            if (32'(cnt_q) + 32'd1 >= RING_SECS) begin
              state_q <= StIdle;
              do_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StSnooze: begin
          if (dis_ev) begin
            state_q <= StIdle;
          end else if (tick_1hz) begin
            if (32'(cnt_q) + 32'd1 >= SNOOZE_SECS) begin
              state_q <= StRing;
              do_q    <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          do_q    <= 1'b0;
        end
      endcase
    end
  end

  assign alarm_mode = state_q;
  assign do_ring    = do_q;
  assign ring_ch    = ring_ch_q;
  assign armed      = armed_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Scoreboard bench for alarm_bank: stimulus tasks update a behavioural model and queue
// expected outputs; a negedge monitor pops and compares against the DUT.
module tb_alarm_bank;

  localparam int N    = 4;
  localparam int TW   = 11;
  localparam int RING = 60;
  localparam int SNZ  = 300;
  localparam int SMAX = 3;
  localparam int CHW  = 2;

  localparam int MIdle = 0, MEdit = 1, MRing = 2, MSnooze = 3;

  logic          newclk = 1'b0;
  logic          rst = 1'b1, tick_1hz = 1'b0;
  logic          middle = 1'b0, dismiss = 1'b0, arm_toggle = 1'b0;
  logic [TW-1:0] hour = '0, minute = '0, second = '0;
  logic [CHW-1:0] sel = '0;
  logic [2:0]     alarm_mode;
  logic           do_ring;
  logic [CHW-1:0] ring_ch;
  logic [N-1:0]   armed;

  always #5 newclk = ~newclk;

  alarm_bank dut (
    .newclk(newclk), .rst(rst), .tick_1hz(tick_1hz),
    .hour(hour), .minute(minute), .second(second),
    .middle(middle), .dismiss(dismiss), .arm_toggle(arm_toggle), .sel(sel),
    .alarm_mode(alarm_mode), .do_ring(do_ring), .ring_ch(ring_ch), .armed(armed)
  );

  typedef struct {
    string tag;
    int    mode;
    int    ch;
    int    arm;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: mode, ringing channel, seconds left in the current phase, snoozes used.
  int m_mode, m_ch, m_edit, m_left, m_snz;
  int m_hr[N];
  int m_mn[N];
  bit m_arm[N];

  function automatic void m_reset();
    m_mode = MIdle; m_ch = 0; m_edit = 0; m_left = 0; m_snz = 0;
    for (int i = 0; i < N; i++) begin
      m_hr[i] = 0; m_mn[i] = 0; m_arm[i] = 1'b0;
    end
  endfunction

  function automatic int arm_mask();
    int m = 0;
    for (int i = 0; i < N; i++) if (m_arm[i]) m += (1 << i);
    return m;
  endfunction

  function automatic void m_middle(int s);
    case (m_mode)
      MIdle: begin m_mode = MEdit; m_edit = s; end
      MEdit: begin
        m_hr[m_edit] = int'(hour); m_mn[m_edit] = int'(minute);
        m_arm[m_edit] = 1'b1; m_mode = MIdle;
      end
      MRing: begin
        if (m_snz < SMAX) begin m_snz++; m_mode = MSnooze; m_left = SNZ; end
        else m_mode = MIdle;
      end
      default: ;
    endcase
  endfunction

  function automatic void m_tick();
    case (m_mode)
      MIdle: begin
        if (second == 0) begin
          for (int i = 0; i < N; i++) begin
            if (m_arm[i] && m_hr[i] == int'(hour) && m_mn[i] == int'(minute)) begin
              m_mode = MRing; m_ch = i; m_left = RING; m_snz = 0;
              break;
            end
          end
        end
      end
      MRing: begin
        m_left--;
        if (m_left == 0) m_mode = MIdle;
      end
      MSnooze: begin
        m_left--;
        if (m_left == 0) begin m_mode = MRing; m_left = RING; end
      end
      default: ;
    endcase
  endfunction

  function automatic void chk(string tag, string what, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s %s: got %0d want %0d", tag, what, got, want);
    end
  endfunction

  always @(negedge newclk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, "mode",    int'(alarm_mode), e.mode);
      chk(e.tag, "do",      int'(do_ring),    (e.mode == MRing) ? 1 : 0);
      chk(e.tag, "ring_ch", int'(ring_ch),    e.ch);
      chk(e.tag, "armed",   int'(armed),      e.arm);
    end
  end

  task automatic expect_now(input string tag);
    exp_t e;
    e.tag = tag; e.mode = m_mode; e.ch = m_ch; e.arm = arm_mask();
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge newclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(1); rst = 1'b0;
    m_reset();
  endtask

  task automatic press(input bit m, input bit d, input bit a, input int s);
    int pre = m_mode;
    sel = CHW'(s); middle = m; dismiss = d; arm_toggle = a;
    cyc(1);
    middle = 1'b0; dismiss = 1'b0; arm_toggle = 1'b0;
    cyc(2);
    if (d && pre != MIdle) m_mode = MIdle;
    else if (m) m_middle(s);
    if (a && pre == MIdle) m_arm[s] = ~m_arm[s];
  endtask

  task automatic tick();
    tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0; cyc(1);
    m_tick();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour = TW'(h); minute = TW'(m); second = TW'(s);
  endtask

  task automatic set_alarm(input int ch, input int h, input int m);
    set_time(h, m, 1);
    press(1, 0, 0, ch);
    press(1, 0, 0, ch);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  initial begin
    cyc(2);
    do_reset();
    expect_now("reset");

    // Single channel edit then trigger.
    set_time(7, 30, 5);
    press(1, 0, 0, 2); expect_now("enter_edit");
    press(1, 0, 0, 2); expect_now("commit_ch2");
    set_time(7, 30, 0); tick(); expect_now("ring_ch2");
    second = TW'(1);
    press(0, 1, 0, 0); expect_now("dismiss_ring");

    // Two channels at the same time: lowest wins; ring runs its full length.
    do_reset();
    set_alarm(0, 6, 0);
    set_alarm(1, 6, 0); expect_now("two_set");
    set_time(6, 0, 0); tick(); expect_now("ring_low_wins");
    second = TW'(1);
    ticks(RING - 1); expect_now("ring_last_sec");
    tick(); expect_now("ring_expired");

    // Snooze cycle until the snooze budget is spent.
    second = TW'(0); tick(); second = TW'(1);
    expect_now("ring_again");
    for (int k = 0; k < SMAX; k++) begin
      press(1, 0, 0, 0); expect_now("snooze");
      ticks(SNZ - 1); expect_now("snooze_last_sec");
      tick(); expect_now("snooze_to_ring");
    end
    press(1, 0, 0, 0); expect_now("snooze_exhausted");

    // Discarded edit leaves the stored time alone; arm toggle round trip.
    set_time(9, 15, 1);
    press(1, 0, 0, 0); press(0, 1, 0, 0); expect_now("edit_discard");
    set_time(6, 0, 0); tick(); expect_now("ch0_time_kept");
    second = TW'(1);
    press(1, 1, 0, 0); expect_now("dismiss_beats_middle");
    press(0, 0, 1, 1); expect_now("arm_toggle_1");
    press(0, 0, 1, 1); expect_now("arm_toggle_2");

    // Reset in the middle of a ring, then prove stored times are zero.
    set_time(6, 0, 0); tick(); second = TW'(1);
    ticks(5); expect_now("pre_reset_ring");
    do_reset(); expect_now("reset_mid_ring");
    press(0, 0, 1, 1);
    set_time(0, 0, 0); tick(); expect_now("zero_time_ring");
    second = TW'(1);
    press(0, 1, 0, 0); expect_now("zero_time_dismiss");

    // Randomised traffic over a small time space so alarms actually fire.
    for (int n = 0; n < 300; n++) begin
      int op = int'($urandom_range(0, 10));
      int s  = int'($urandom_range(0, N - 1));
      case (op)
        0, 1:    tick();
        2:       press(1, 0, 0, s);
        3:       press(0, 1, 0, s);
        4:       press(0, 0, 1, s);
        5:       press(1, 1, 0, s);
        6, 7:    set_time(int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 1)));
        8:       ticks(int'($urandom_range(5, 40)));
        9:       if ($urandom_range(0, 7) == 0) do_reset();
        default: begin set_time(1, 1, 0); tick(); end
      endcase
      expect_now("random");
    end

    cyc(3);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
